lcd_pixel_driver: RTL
=====================

Name: lcd_pixel_driver

Overview:
- Downstream consumer of the pixel FIFO filled by the SDRAM frame reader; generates LCD panel timing (pixel clock, HSync, VSync, DE) and pops one 16-bit RGB565 pixel per active pixel.
- Holds the panel blank until the frame reader reports its first burst landed, then runs free-running raster timing.
- Flags FIFO underflow so bring-up can tell bandwidth starvation from timing faults.

Parameters:
- H_ACTIVE, 480, active pixels per line (matches 480-wide frame buffer)
- H_FP, 8, horizontal front porch (pixel ticks)
- H_SYNC, 4, HSync width
- H_BP, 43, horizontal back porch
- V_ACTIVE, 200, active lines per frame (480x200 frame buffer)
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 10, VSync width
- V_BP, 12, vertical back porch
- CLK_DIV, 4, i_Clk cycles per pixel tick; even, >=2
- SYNC_ACTIVE_LOW, 1, 1 = HSync/VSync asserted low

Ports:
- i_Clk  in  1  system clock (same domain as SDRAM/FIFO read side)
- i_Reset  in  1  synchronous, active-high reset
- i_First_Data_Ready  in  1  level from frame reader; FIFO holds valid pixels
- i_Pixel_Data  in  16  FIFO head word (show-ahead FIFO, valid when not empty)
- i_Pixel_Out_Empty  in  1  FIFO read-side empty
- o_FIFO_Rd  out  1  one-cycle pop strobe
- o_LCD_Clk  out  1  pixel clock to panel, 50% duty
- o_HSync  out  1  horizontal sync
- o_VSync  out  1  vertical sync
- o_DE  out  1  data enable
- o_RGB  out  16  RGB565 pixel
- o_Underflow  out  1  sticky underflow flag

Behaviour:
- Reset: state WAIT, h_count=0, v_count=0, div_count=0, o_LCD_Clk=0, syncs deasserted (1 if SYNC_ACTIVE_LOW), o_DE=0, o_RGB=0, o_FIFO_Rd=0, o_Underflow=0. Reset mid-frame aborts immediately to these values.
- Divider: div_count 0..CLK_DIV-1 wraps; pixel tick = (div_count==CLK_DIV-1). o_LCD_Clk low for first half, high for second half; outputs change on tick, so panel samples on o_LCD_Clk rising edge mid-pixel.
- States: WAIT -> RUN when i_First_Data_Ready=1 sampled on a tick; counters start at (0,0) on that tick. RUN -> WAIT only via reset (i_First_Data_Ready deasserting is ignored). In WAIT: divider and o_LCD_Clk run, counters held, outputs idle.
- Counters (RUN, per tick): h_count 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP); at wrap h_count->0, v_count increments, wraps at V_TOTAL-1 -> 0. Widths sized by $clog2 of totals.
- Line order: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch; vertical identical in lines.
- Registered outputs updated on tick from current counters: o_HSync/o_VSync asserted in sync windows; o_DE=1 iff h and v both active.
- Active pixel, FIFO not empty: o_RGB<=i_Pixel_Data, o_FIFO_Rd=1 for exactly that one i_Clk cycle (the tick cycle). Exactly one pop per active pixel; H_ACTIVE*V_ACTIVE=96000 pops per frame.
- Active pixel, FIFO empty: o_RGB<=0, no pop, o_Underflow<=1 (sticky until reset), o_DE still 1.
- Non-active: o_RGB<=0, o_FIFO_Rd=0.
- Never pop when empty; never more than one pop per tick.

Decomposition:
- Shared package/header (alongside sdram.vh): panel timing defaults (H_/V_ constants), FRAME_PIXELS=480*200, state encodings WAIT/RUN, RGB565 width.
- One natural sub-module: lcd_sync_counter (one instance each for horizontal/vertical: count, wrap strobe, active/sync window decode from ACTIVE/FP/SYNC/BP parameters).

Test Plan:
- Reset, i_First_Data_Ready=0 for 1000 cycles -> o_DE=0, no o_FIFO_Rd, o_LCD_Clk toggles with period CLK_DIV=4 cycles, syncs idle high.
- Assert ready, FIFO model always non-empty, incrementing data -> first tick: o_DE=1, o_RGB=0x0000; line has 480 DE ticks; HSync low for 4 ticks starting 488 ticks after line start; line period 535 ticks.
- Full frame -> 96000 pops, o_RGB sequence matches FIFO order, VSync low for 10 lines starting at line 202, frame period 224*535 ticks, o_Underflow=0.
- Force empty for pixels 100..102 of line 5 -> o_RGB=0, no pops for those 3 ticks, o_Underflow=1 and stays 1; pop resumes at pixel 103.
- Deassert i_First_Data_Ready mid-frame -> timing continues unchanged.
- Assert i_Reset at h=250,v=50 -> next cycle all outputs at reset values, WAIT; after re-ready raster restarts at (0,0).

Source files
------------

// File: rtl/lcd_pixel_driver_pkg.sv
// Panel timing defaults, FSM encodings and sizing helpers shared by the LCD pixel driver.
// Purely declarative: no logic, no latency, no flow control.
package lcd_pixel_driver_pkg;

    localparam int H_ACTIVE_DEF = 480;
    localparam int H_FP_DEF     = 8;
    localparam int H_SYNC_DEF   = 4;
    localparam int H_BP_DEF     = 43;

    localparam int V_ACTIVE_DEF = 200;
    localparam int V_FP_DEF     = 2;
    localparam int V_SYNC_DEF   = 10;
    localparam int V_BP_DEF     = 12;

    localparam int CLK_DIV_DEF  = 4;
    localparam int FRAME_PIXELS = H_ACTIVE_DEF * V_ACTIVE_DEF;
    localparam int RGB_W        = 16;

    localparam logic [0:0] ST_WAIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lcd_sync_counter.sv
// One raster axis: counts 0..TOTAL-1 on i_En, flags wrap and decodes active/sync windows.
// Decodes are combinational from the current count; no backpressure, advances only on i_En.
module lcd_sync_counter
    import lcd_pixel_driver_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_En,
    output logic o_Wrap,
    output logic o_Active,
    output logic o_Sync
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam int W     = cnt_width(TOTAL);

    // One extra bit so window edges equal to 2**W still compare correctly.
    localparam logic [W:0] LAST       = (W+1)'(TOTAL - 1);
    localparam logic [W:0] ACT_END    = (W+1)'(ACTIVE);
    localparam logic [W:0] SYNC_START = (W+1)'(ACTIVE + FP);
    localparam logic [W:0] SYNC_END   = (W+1)'(ACTIVE + FP + SYNC);

    logic [W-1:0] r_count;
    logic [W:0]   w_count_x;

    assign w_count_x = {1'b0, r_count};

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_count <= '0;
        end else if (i_En) begin
            if (w_count_x == LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + W'(1);
            end
        end
    end

    assign o_Wrap   = i_En && (w_count_x == LAST);
    assign o_Active = (w_count_x < ACT_END);
    assign o_Sync   = (w_count_x >= SYNC_START) && (w_count_x < SYNC_END);

endmodule

// File: rtl/lcd_pixel_driver.sv
// LCD raster timing generator popping one RGB565 word from a show-ahead FIFO per active pixel.
// Outputs register on each pixel tick (CLK_DIV cycles); an empty FIFO never stalls timing, it blanks and flags underflow.
module lcd_pixel_driver
    import lcd_pixel_driver_pkg::*;
#(
    parameter int H_ACTIVE        = H_ACTIVE_DEF,
    parameter int H_FP            = H_FP_DEF,
    parameter int H_SYNC          = H_SYNC_DEF,
    parameter int H_BP            = H_BP_DEF,
    parameter int V_ACTIVE        = V_ACTIVE_DEF,
    parameter int V_FP            = V_FP_DEF,
    parameter int V_SYNC          = V_SYNC_DEF,
    parameter int V_BP            = V_BP_DEF,
    parameter int CLK_DIV         = CLK_DIV_DEF,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_First_Data_Ready,
    input  logic [RGB_W-1:0] i_Pixel_Data,
    input  logic             i_Pixel_Out_Empty,
    output logic             o_FIFO_Rd,
    output logic             o_LCD_Clk,
    output logic             o_HSync,
    output logic             o_VSync,
    output logic             o_DE,
    output logic [RGB_W-1:0] o_RGB,
    output logic             o_Underflow
);

    localparam int             DIV_W     = cnt_width(CLK_DIV);
    localparam logic [DIV_W:0] DIV_LAST  = (DIV_W+1)'(CLK_DIV - 1);
    localparam logic [DIV_W:0] DIV_HALF  = (DIV_W+1)'(CLK_DIV / 2);
    localparam logic           SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic             r_lcd_clk;
    logic [0:0]       r_state;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic [RGB_W-1:0] r_rgb;
    logic             r_underflow;

    logic w_tick;
    logic w_pix_tick;
    logic w_h_wrap;
    logic w_h_active;
    logic w_h_sync;
    logic w_v_wrap;
    logic w_v_active;
    logic w_v_sync;
    logic w_active;
    logic w_fifo_rd;

    assign w_tick     = ({1'b0, r_div} == DIV_LAST);
    assign w_div_next = w_tick ? '0 : r_div + DIV_W'(1);

    // The tick that sees ready in WAIT already emits pixel (0,0).
    assign w_pix_tick = w_tick && ((r_state == ST_RUN) || i_First_Data_Ready);
    assign w_active   = w_h_active && w_v_active;
    assign w_fifo_rd  = w_pix_tick && w_active && !i_Pixel_Out_Empty && !i_Reset;

    lcd_sync_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_cnt (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_En     (w_pix_tick),
        .o_Wrap   (w_h_wrap),
        .o_Active (w_h_active),
        .o_Sync   (w_h_sync)
    );

    lcd_sync_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_cnt (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_En     (w_h_wrap),
        .o_Wrap   (w_v_wrap),
        .o_Active (w_v_active),
        .o_Sync   (w_v_sync)
    );

    // Low for the first half of the pixel period so the panel samples mid-pixel.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_div     <= '0;
            r_lcd_clk <= 1'b0;
        end else begin
            r_div     <= w_div_next;
            r_lcd_clk <= ({1'b0, w_div_next} >= DIV_HALF);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state <= ST_WAIT;
        end else if (w_tick && (r_state == ST_WAIT) && i_First_Data_Ready) begin
            r_state <= ST_RUN;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_hsync     <= SYNC_IDLE;
            r_vsync     <= SYNC_IDLE;
            r_de        <= 1'b0;
            r_rgb       <= '0;
            r_underflow <= 1'b0;
        end else if (w_pix_tick) begin
            r_hsync <= w_h_sync ? !SYNC_IDLE : SYNC_IDLE;
            r_vsync <= w_v_sync ? !SYNC_IDLE : SYNC_IDLE;
            r_de    <= w_active;
            r_rgb   <= w_fifo_rd ? i_Pixel_Data : '0;
            if (w_active && i_Pixel_Out_Empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_FIFO_Rd   = w_fifo_rd;
    assign o_LCD_Clk   = r_lcd_clk;
    assign o_HSync     = r_hsync;
    assign o_VSync     = r_vsync;
    assign o_DE        = r_de;
    assign o_RGB       = r_rgb;
    assign o_Underflow = r_underflow;

    // Frame wrap needs no action: the vertical counter returns to 0 by itself.
    logic w_unused;
    assign w_unused = w_v_wrap;

endmodule
